// File: rtl/mips_multicycle_ctrl_pkg.sv
// mipspkg: shared types for the multicycle MIPS control path.
//   opcode_t    : primary opcode field IR[31:26] values the controller decodes
//   alu_t       : ALU operation class passed to aludec (alu_FUNCT defers to funct)
//   ctrlstate_t : main control FSM states (S_TRAP only reachable when
//                 MIPS_ILLEGAL_TRAP_EN is defined)
package mipspkg;

   typedef enum logic [5:0] {
      R_TYPE = 6'd0,
      J      = 6'd2,
      BEQ    = 6'd4,
      BNE    = 6'd5,
      ADDI   = 6'd8,
      SLTI   = 6'd10,
      ANDI   = 6'd12,
      ORI    = 6'd13,
      XORI   = 6'd14,
      LUI    = 6'd15,
      LW     = 6'd35,
      SW     = 6'd43
   } opcode_t;

   typedef enum logic [3:0] {
      alu_ADD   = 4'd0,
      alu_SUB   = 4'd1,
      alu_AND   = 4'd2,
      alu_OR    = 4'd3,
      alu_XOR   = 4'd4,
      alu_SLT   = 4'd5,
      alu_LUI   = 4'd6,
      alu_FUNCT = 4'd15
   } alu_t;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTYPE  = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } ctrlstate_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: control bundle between the main FSM and the datapath.
//   Datapath -> controller : op, zero, mem_ready
//   Controller -> datapath : PC/IR/regfile strobes, mux selects, aluop
// Handshake: the controller raises memread or memwrite and holds the request,
// address select and state unchanged until a cycle with mem_ready=1; that
// cycle completes the access. mem_ready is ignored in every other cycle.
interface mips_multicycle_ctrl_if;
   import mipspkg::*;

   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pcen;
   logic       pcwrite;
   logic       branch;
   logic       bne;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       irwrite;
   logic       memtoreg;
   logic       regdst;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       zext;
   logic [1:0] pcsrc;
   alu_t       aluop;

   modport master (
      input  op, zero, mem_ready,
      output pcen, pcwrite, branch, bne, iord, memread, memwrite, irwrite,
             memtoreg, regdst, regwrite, alusrca, alusrcb, zext, pcsrc, aluop
   );

   modport slave (
      output op, zero, mem_ready,
      input  pcen, pcwrite, branch, bne, iord, memread, memwrite, irwrite,
             memtoreg, regdst, regwrite, alusrca, alusrcb, zext, pcsrc, aluop
   );

endinterface

// File: rtl/mips_multicycle_ctrl_immop_dec.sv
// mips_immop_dec: opcode to {aluop, zext} mapping for immediate-ALU ops.
//   op    : opcode field
//   aluop : ALU class for the IMMEX cycle (alu_ADD for anything unlisted)
//   zext  : zero-extend the immediate (logical immediates only)
module mips_immop_dec
   import mipspkg::*;
(
   input  logic [5:0] op,
   output alu_t       aluop,
   output logic       zext
);

   always_comb begin
      aluop = alu_ADD;
      zext  = 1'b0;
      case (opcode_t'(op))
         ADDI: aluop = alu_ADD;
         SLTI: aluop = alu_SLT;
         ANDI: begin aluop = alu_AND; zext = 1'b1; end
         ORI:  begin aluop = alu_OR;  zext = 1'b1; end
         XORI: begin aluop = alu_XOR; zext = 1'b1; end
         LUI:  aluop = alu_LUI;
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS datapath.
//   clk, reset_n : clock, synchronous active-low reset
//   ctrl         : control bundle (op/zero/mem_ready in, strobes/selects out)
//   instret      : retired-instruction counter, IRET_W bits, wraps
//   illegal_op   : sticky illegal-opcode flag
//   dbg_state    : current FSM state
// Build option MIPS_ILLEGAL_TRAP_EN: an illegal opcode parks the FSM in
// S_TRAP until reset and sets illegal_op; otherwise it is skipped as a NOP.
module mips_multicycle_ctrl
   import mipspkg::*;
#(
   parameter int IRET_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   mips_multicycle_ctrl_if.master ctrl,
   output logic [IRET_W-1:0]     instret,
   output logic                  illegal_op,
   output ctrlstate_t            dbg_state
);

   ctrlstate_t state, next_state, out_state;
   alu_t       imm_aluop, aluop_r;
   logic       imm_zext, retire;
   logic       pcwrite_r, branch_r, memread_r, memwrite_r, irwrite_r, regwrite_r;
   logic       bne_r, iord_r, memtoreg_r, regdst_r, alusrca_r, zext_r;
   logic [1:0] alusrcb_r, pcsrc_r;

   mips_immop_dec u_immop_dec (
      .op    (ctrl.op),
      .aluop (imm_aluop),
      .zext  (imm_zext)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_FETCH;
         instret <= '0;
      end else begin
         state <= next_state;
         if (retire) instret <= instret + IRET_W'(1);
      end
   end

   // Last cycle of every legal instruction; MEMWR only once the store lands.
   assign retire = reset_n & ((state == S_MEMWB) | (state == S_ALUWB) |
                              (state == S_IMMWB) | (state == S_BRANCH) |
                              (state == S_JUMP) |
                              ((state == S_MEMWR) & ctrl.mem_ready));

   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = ctrl.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode_t'(ctrl.op))
               R_TYPE:                            next_state = S_RTYPE;
               LW, SW:                            next_state = S_MEMADR;
               BEQ, BNE:                          next_state = S_BRANCH;
               J:                                 next_state = S_JUMP;
               ADDI, SLTI, ANDI, ORI, XORI, LUI:  next_state = S_IMMEX;
`ifdef MIPS_ILLEGAL_TRAP_EN
               default:                           next_state = S_TRAP;
`else
               default:                           next_state = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: next_state = (ctrl.op == LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  next_state = ctrl.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  next_state = ctrl.mem_ready ? S_FETCH : S_MEMWR;
         S_RTYPE:  next_state = S_ALUWB;
         S_IMMEX:  next_state = S_IMMWB;
`ifdef MIPS_ILLEGAL_TRAP_EN
         S_TRAP:   next_state = S_TRAP;
`endif
         default:  next_state = S_FETCH;
      endcase
   end

   // While reset is held the outputs decode as FETCH, so an abandoned
   // instruction cannot leak selects; strobes are additionally gated below.
   assign out_state = reset_n ? state : S_FETCH;

   always_comb begin
      pcwrite_r  = 1'b0;
      branch_r   = 1'b0;
      memread_r  = 1'b0;
      memwrite_r = 1'b0;
      irwrite_r  = 1'b0;
      regwrite_r = 1'b0;
      bne_r      = 1'b0;
      iord_r     = 1'b0;
      memtoreg_r = 1'b0;
      regdst_r   = 1'b0;
      alusrca_r  = 1'b0;
      zext_r     = 1'b0;
      alusrcb_r  = 2'b00;
      pcsrc_r    = 2'b00;
      aluop_r    = alu_ADD;
      case (out_state)
         S_FETCH: begin
            memread_r = 1'b1;
            alusrcb_r = 2'b01;
            irwrite_r = ctrl.mem_ready;
            pcwrite_r = ctrl.mem_ready;
         end
         S_DECODE: alusrcb_r = 2'b11;
         S_MEMADR: begin alusrca_r = 1'b1; alusrcb_r = 2'b10; end
         S_MEMRD:  begin iord_r = 1'b1; memread_r = 1'b1; end
         S_MEMWB:  begin regwrite_r = 1'b1; memtoreg_r = 1'b1; end
         S_MEMWR:  begin iord_r = 1'b1; memwrite_r = 1'b1; end
         S_RTYPE:  begin alusrca_r = 1'b1; aluop_r = alu_FUNCT; end
         S_ALUWB:  begin regwrite_r = 1'b1; regdst_r = 1'b1; end
         S_BRANCH: begin
            alusrca_r = 1'b1;
            aluop_r   = alu_SUB;
            branch_r  = 1'b1;
            pcsrc_r   = 2'b01;
            bne_r     = (ctrl.op == BNE);
         end
         S_IMMEX: begin
            alusrca_r = 1'b1;
            alusrcb_r = 2'b10;
            aluop_r   = imm_aluop;
            zext_r    = imm_zext;
         end
         S_IMMWB:  regwrite_r = 1'b1;
         S_JUMP:   begin pcwrite_r = 1'b1; pcsrc_r = 2'b10; end
         default: ;
      endcase
   end

   assign ctrl.pcwrite  = pcwrite_r  & reset_n;
   assign ctrl.branch   = branch_r   & reset_n;
   assign ctrl.memread  = memread_r  & reset_n;
   assign ctrl.memwrite = memwrite_r & reset_n;
   assign ctrl.irwrite  = irwrite_r  & reset_n;
   assign ctrl.regwrite = regwrite_r & reset_n;
   assign ctrl.pcen     = (pcwrite_r | (branch_r & (ctrl.zero ^ bne_r))) & reset_n;
   assign ctrl.bne      = bne_r;
   assign ctrl.iord     = iord_r;
   assign ctrl.memtoreg = memtoreg_r;
   assign ctrl.regdst   = regdst_r;
   assign ctrl.alusrca  = alusrca_r;
   assign ctrl.alusrcb  = alusrcb_r;
   assign ctrl.zext     = zext_r;
   assign ctrl.pcsrc    = pcsrc_r;
   assign ctrl.aluop    = aluop_r;
   assign dbg_state     = state;

`ifdef MIPS_ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk) begin
      if (!reset_n) illegal_q <= 1'b0;
      else if ((state == S_DECODE) && (next_state == S_TRAP)) illegal_q <= 1'b1;
   end
   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table vectors, hand sequences for reset/trap
// corners, then randomized instructions checked against an
// instruction-level model (latency, strobe counts, exec-cycle ALU class).
module tb_mips_multicycle_ctrl;
   import mipspkg::*;

   localparam int IRET_W = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [IRET_W-1:0] instret;
   logic              illegal_op;
   ctrlstate_t        dbg_state;

   mips_multicycle_ctrl_if bus ();

   mips_multicycle_ctrl #(.IRET_W(IRET_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ctrl       (bus.master),
      .instret    (instret),
      .illegal_op (illegal_op),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         len;
      alu_t       aluop;
      logic       zext;
      logic [1:0] pcsrc;
      int         pcen_cnt;
      int         pcw_cnt;
      int         rw_cnt;
      logic       mtr;
      logic       rdst;
      int         mw_cnt;
      int         mr_cnt;
      int         ret;
   } exp_t;

   typedef struct {
      logic [5:0] op;
      logic       zero;
      int         sf;
      int         sm;
      exp_t       e;
   } vec_t;

   int                checks = 0;
   int                failures = 0;
   logic [IRET_W-1:0] exp_instret;
   vec_t              vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] strobes();
      return {bus.pcwrite, bus.pcen, bus.irwrite, bus.regwrite,
              bus.memwrite, bus.memread, bus.branch};
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12,
                        6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
   endfunction

   function automatic vec_t mkv(input logic [5:0] op, input logic zero, input int sf,
                                input int sm, input int len, input alu_t aluop,
                                input logic zext, input logic [1:0] pcsrc, input int pcen,
                                input int pcw, input int rw, input logic mtr,
                                input logic rdst, input int mw, input int mr, input int ret);
      vec_t v;
      v.op = op; v.zero = zero; v.sf = sf; v.sm = sm;
      v.e.len = len; v.e.aluop = aluop; v.e.zext = zext; v.e.pcsrc = pcsrc;
      v.e.pcen_cnt = pcen; v.e.pcw_cnt = pcw; v.e.rw_cnt = rw; v.e.mtr = mtr;
      v.e.rdst = rdst; v.e.mw_cnt = mw; v.e.mr_cnt = mr; v.e.ret = ret;
      return v;
   endfunction

   // Instruction-level reference: what one instruction must do overall.
   function automatic exp_t model(input logic [5:0] op, input logic zero, input int sf, input int sm);
      exp_t e;
      e.len = sf + 2; e.aluop = alu_ADD; e.zext = 1'b0; e.pcsrc = 2'b00;
      e.pcen_cnt = 1; e.pcw_cnt = 1; e.rw_cnt = 0; e.mtr = 1'b0; e.rdst = 1'b0;
      e.mw_cnt = 0; e.mr_cnt = 0; e.ret = 0;
      if (op == 6'd0) begin
         e.len = sf + 4; e.aluop = alu_FUNCT; e.rw_cnt = 1; e.rdst = 1'b1; e.ret = 1;
      end else if (op == 6'd35) begin
         e.len = sf + sm + 5; e.rw_cnt = 1; e.mtr = 1'b1; e.mr_cnt = sm + 1; e.ret = 1;
      end else if (op == 6'd43) begin
         e.len = sf + sm + 4; e.mw_cnt = sm + 1; e.ret = 1;
      end else if (op == 6'd4 || op == 6'd5) begin
         e.len = sf + 3; e.aluop = alu_SUB; e.pcsrc = 2'b01; e.ret = 1;
         if ((op == 6'd5) ? !zero : zero) e.pcen_cnt = 2;
      end else if (op == 6'd2) begin
         e.len = sf + 3; e.pcsrc = 2'b10; e.pcen_cnt = 2; e.pcw_cnt = 2; e.ret = 1;
      end else if (is_legal(op)) begin
         e.len = sf + 4; e.rw_cnt = 1; e.ret = 1;
         case (op)
            6'd10: e.aluop = alu_SLT;
            6'd12: begin e.aluop = alu_AND; e.zext = 1'b1; end
            6'd13: begin e.aluop = alu_OR;  e.zext = 1'b1; end
            6'd14: begin e.aluop = alu_XOR; e.zext = 1'b1; end
            6'd15: e.aluop = alu_LUI;
            default: e.aluop = alu_ADD;
         endcase
      end
      return e;
   endfunction

   task automatic check_fetch_now(input string tag);
      chk({tag, ".state"}, 32'(dbg_state), 32'(S_FETCH));
      chk({tag, ".instret"}, 32'(instret), 32'(exp_instret));
      chk({tag, ".illegal"}, 32'(illegal_op), 32'd0);
      chk({tag, ".fetch_mr_iord"}, {30'd0, bus.memread, bus.iord}, 32'b10);
   endtask

   task automatic do_reset(input string tag);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         reset_n = 1'b0;
         bus.mem_ready = 1'b1;
         bus.op = 6'($urandom_range(0, 63));
         bus.zero = 1'($urandom_range(0, 1));
         #1;
         chk($sformatf("%s.rst%0d.strobes", tag, c), 32'(strobes()), 32'd0);
         chk($sformatf("%s.rst%0d.sel", tag, c), {29'd0, bus.iord, bus.alusrcb}, 32'b001);
      end
      exp_instret = '0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int         irw = 0, pcw = 0, pcen = 0, rw = 0, mw = 0, mr = 0;
      logic       mtr_s = 1'b0, rdst_s = 1'b0, zext_s = 1'b0;
      logic [1:0] pcsrc_s = 2'b00;
      alu_t       alu_s = alu_ADD;
      bit         memop;
      memop = (v.op == 6'd35) || (v.op == 6'd43);
      for (int c = 0; c < v.e.len; c++) begin
         @(negedge clk);
         reset_n = 1'b1;
         bus.op = (c <= v.sf) ? 6'($urandom_range(0, 63)) : v.op;
         bus.zero = (c == v.sf + 2) ? v.zero : 1'($urandom_range(0, 1));
         if (c < v.sf) bus.mem_ready = 1'b0;
         else if (c == v.sf) bus.mem_ready = 1'b1;
         else if (memop && c >= v.sf + 3 && c < v.sf + 3 + v.sm) bus.mem_ready = 1'b0;
         else if (memop && c == v.sf + 3 + v.sm) bus.mem_ready = 1'b1;
         else bus.mem_ready = 1'($urandom_range(0, 1));
         #1;
         if (c == 0) check_fetch_now(tag);
         if (c == v.sf) chk({tag, ".fetch_irw_pcw"}, {30'd0, bus.irwrite, bus.pcwrite}, 32'b11);
         irw += int'(bus.irwrite);
         pcw += int'(bus.pcwrite);
         pcen += int'(bus.pcen);
         mw += int'(bus.memwrite);
         mr += int'(bus.memread & bus.iord);
         if (bus.regwrite) begin
            rw++; mtr_s = bus.memtoreg; rdst_s = bus.regdst;
         end
         if (c == v.sf + 2) begin
            alu_s = bus.aluop; zext_s = bus.zext; pcsrc_s = bus.pcsrc;
         end
      end
      exp_instret = exp_instret + IRET_W'(v.e.ret);
      chk({tag, ".irwrite_cnt"}, 32'(irw), 32'd1);
      chk({tag, ".pcwrite_cnt"}, 32'(pcw), 32'(v.e.pcw_cnt));
      chk({tag, ".pcen_cnt"}, 32'(pcen), 32'(v.e.pcen_cnt));
      chk({tag, ".regwrite_cnt"}, 32'(rw), 32'(v.e.rw_cnt));
      chk({tag, ".memwrite_cnt"}, 32'(mw), 32'(v.e.mw_cnt));
      chk({tag, ".memread_data_cnt"}, 32'(mr), 32'(v.e.mr_cnt));
      if (v.e.rw_cnt > 0)
         chk({tag, ".wb_mtr_rdst"}, {30'd0, mtr_s, rdst_s}, {30'd0, v.e.mtr, v.e.rdst});
      if (v.e.len > v.sf + 2) begin
         chk({tag, ".exec_aluop"}, 32'(alu_s), 32'(v.e.aluop));
         chk({tag, ".exec_zext_pcsrc"}, {29'd0, zext_s, pcsrc_s}, {29'd0, v.e.zext, v.e.pcsrc});
      end
   endtask

   initial begin
      bus.op = 6'd0;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;
      exp_instret = '0;

      // op, zero, sf, sm | len, aluop, zext, pcsrc, pcen, pcw, rw, mtr, rdst, mw, mr, ret
      vecs.push_back(mkv(6'd0,  0, 0, 0, 4, alu_FUNCT, 0, 2'd0, 1, 1, 1, 0, 1, 0, 0, 1));
      vecs.push_back(mkv(6'd35, 0, 0, 3, 8, alu_ADD,   0, 2'd0, 1, 1, 1, 1, 0, 0, 4, 1));
      vecs.push_back(mkv(6'd5,  0, 0, 0, 3, alu_SUB,   0, 2'd1, 2, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd4,  0, 0, 0, 3, alu_SUB,   0, 2'd1, 1, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd4,  1, 0, 0, 3, alu_SUB,   0, 2'd1, 2, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd5,  1, 0, 0, 3, alu_SUB,   0, 2'd1, 1, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd13, 0, 0, 0, 4, alu_OR,    1, 2'd0, 1, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd15, 0, 0, 0, 4, alu_LUI,   0, 2'd0, 1, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd43, 0, 2, 1, 7, alu_ADD,   0, 2'd0, 1, 1, 0, 0, 0, 2, 0, 1));
      vecs.push_back(mkv(6'd2,  0, 1, 0, 4, alu_ADD,   0, 2'd2, 2, 2, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd8,  0, 1, 0, 5, alu_ADD,   0, 2'd0, 1, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd10, 0, 0, 0, 4, alu_SLT,   0, 2'd0, 1, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd12, 0, 0, 0, 4, alu_AND,   1, 2'd0, 1, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd14, 0, 0, 0, 4, alu_XOR,   1, 2'd0, 1, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mkv(6'd35, 0, 0, 0, 5, alu_ADD,   0, 2'd0, 1, 1, 1, 1, 0, 0, 1, 1));
`ifndef MIPS_ILLEGAL_TRAP_EN
      vecs.push_back(mkv(6'd63, 0, 0, 0, 2, alu_ADD,   0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0));
`endif

      do_reset("init");
      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of a stalled load.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         reset_n = 1'b1;
         bus.op = 6'd35;
         bus.mem_ready = (c == 0);
         #1;
      end
      chk("midrst.in_memrd", {30'd0, bus.memread, bus.iord}, 32'b11);
      do_reset("midrst");

`ifdef MIPS_ILLEGAL_TRAP_EN
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         reset_n = 1'b1;
         bus.op = 6'd63;
         bus.mem_ready = 1'($urandom_range(0, 1));
         if (c == 0) bus.mem_ready = 1'b1;
         #1;
         if (c >= 2) begin
            chk($sformatf("trap%0d.strobes", c), 32'(strobes()), 32'd0);
            chk($sformatf("trap%0d.illegal", c), 32'(illegal_op), 32'd1);
            chk($sformatf("trap%0d.instret", c), 32'(instret), 32'(exp_instret));
         end
      end
      do_reset("trap");
`endif

      for (int n = 0; n < 40; n++) begin
         vec_t       v;
         logic [5:0] op;
         op = 6'($urandom_range(0, 63));
`ifdef MIPS_ILLEGAL_TRAP_EN
         while (!is_legal(op)) op = 6'($urandom_range(0, 63));
`else
         if ($urandom_range(0, 7) != 0)
            while (!is_legal(op)) op = 6'($urandom_range(0, 63));
`endif
         v.op = op;
         v.zero = 1'($urandom_range(0, 1));
         v.sf = $urandom_range(0, 2);
         v.sm = $urandom_range(0, 3);
         v.e = model(v.op, v.zero, v.sf, v.sm);
         run_vec(v, $sformatf("rnd%0d_op%0d", n, op));
      end

      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      check_fetch_now("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
